parity_appender: RTL
====================

PARITY_APPENDER -- requirements
Module: parity_appender

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, as the tdata width in bits on both ports.
REQ-002 The block SHALL have parameter ODD_PARITY, default 0, where 0 selects an even-parity trailer and 1 selects odd parity (trailer inverted).
REQ-003 The block SHALL have parameter CNT_W, default 16, as the width of the packet counter.
REQ-004 The block SHALL have port in_clock, input, 1 bit: sole clock; all logic is rising-edge.
REQ-005 The block SHALL have port axis_areset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port axis_s_tvalid, input, 1 bit: upstream beat valid.
REQ-007 The block SHALL have port axis_s_tdata, input, DATA_W bits: upstream payload byte.
REQ-008 The block SHALL have port axis_s_tready, output, 1 bit: block accepts an upstream beat.
REQ-009 The block SHALL have port axis_s_tlast, input, 1 bit: last payload beat of a packet.
REQ-010 The block SHALL have port axis_m_tvalid, output, 1 bit: downstream beat valid, feeding the parity tester's slave port.
REQ-011 The block SHALL have port axis_m_tdata, output, DATA_W bits: payload or parity trailer.
REQ-012 The block SHALL have port axis_m_tready, input, 1 bit: downstream accepts a beat.
REQ-013 The block SHALL have port axis_m_tlast, output, 1 bit: asserted only on the trailer beat.
REQ-014 The block SHALL have port pkt_count, output, CNT_W bits: number of complete packets emitted.

Function
REQ-015 Transfers SHALL occur only on cycles where tvalid and tready are both high (handshake); once axis_m_tvalid rises, it and axis_m_tdata/tlast SHALL hold until a handshake.
REQ-016 Each accepted payload beat SHALL appear on the master port with latency 1 cycle when axis_m_tready is high, in order, with axis_m_tlast=0.
REQ-017 Full throughput of 1 beat per cycle SHALL be sustained during payload; a 2-entry skid buffer SHALL absorb one beat when the master port stalls, and axis_s_tready SHALL be registered (no combinational tready path from m to s).
REQ-018 The accumulator acc SHALL be XORed with each accepted payload byte, and SHALL be cleared to 0 when a trailer handshake occurs.
REQ-019 The FSM SHALL have states IDLE, PASS and TRAIL: IDLE goes to PASS on the first accepted beat; PASS goes to TRAIL on an accepted beat with tlast=1; TRAIL goes to IDLE on a trailer handshake.
REQ-020 The trailer SHALL equal the XOR of all payload bytes of the packet, XOR all-ones when ODD_PARITY=1, and SHALL be emitted immediately after the last payload beat with axis_m_tlast=1.
REQ-021 axis_s_tready SHALL be 0 from acceptance of a tlast beat until the trailer handshake; the next packet's first beat SHALL be acceptable in the cycle after that handshake.
REQ-022 A single-beat packet (tlast on the first beat) SHALL produce 2 output beats: the payload byte, then the trailer.
REQ-023 pkt_count SHALL increment by 1 on each trailer handshake and SHALL wrap from 2^CNT_W-1 to 0.
REQ-024 Input beats SHALL never be dropped or duplicated under any pattern of axis_m_tready, including when a stall coincides with an input tlast.

Reset
REQ-025 While axis_areset=1, asynchronously: axis_m_tvalid=0, axis_m_tdata=0, axis_m_tlast=0, axis_s_tready=0, pkt_count=0, acc=0, FSM=IDLE, and the skid buffer SHALL be empty.
REQ-026 axis_s_tready SHALL rise on the first clock edge after reset deasserts.
REQ-027 A reset mid-packet SHALL discard the partial packet with no trailer and no pkt_count change.

Structure
REQ-028 Package parity_pkg SHALL hold DATA_W and CNT_W defaults, the FSM state enum {IDLE,PASS,TRAIL}, and the odd-parity mask constant.
REQ-029 The skid buffer SHALL be the sub-module axis_skid_buffer (2 entries, parameterised width), instantiated once on the payload path; the FSM, accumulator, trailer mux and counter SHALL live in the top level.

Verification
REQ-030 Bench case: with m_tready=1 held, send packet 0x01,0x02,0x04(tlast) -> expect out 0x01,0x02,0x04,0x07(tlast), pkt_count=1.
REQ-031 Bench case: with ODD_PARITY=1, send single beat 0xA5(tlast) -> expect out 0xA5, then 0x5A(tlast).
REQ-032 Bench case: hold m_tready=0 for 5 cycles mid-packet -> expect s_tready to drop after ≤2 buffered beats, no loss, data/valid stable, correct trailer.
REQ-033 Bench case: send back-to-back packets with m_tready=1 -> expect s_tready low exactly for the trailer cycle(s), and pkt_count counting 1,2,3.
REQ-034 Bench case: assert reset after 2 beats of a 4-beat packet, then send 0xFF(tlast) -> expect out 0xFF, 0xFF(tlast); pkt_count=1.
REQ-035 Bench case: preload the count so that 2^CNT_W packets complete -> expect pkt_count to wrap to 0.

Source files
------------

// File: rtl/parity_pkg.sv
// parity_pkg: shared defaults, FSM state encoding and odd-parity mask for the parity appender.
package parity_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam logic [63:0] ODD_MASK = '1;
  typedef enum logic [1:0] {IDLE, PASS, TRAIL} state_e;
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry AXI-Stream skid buffer; s_ready_o is a flop so no m->s ready path exists.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         s_valid_i,
  input  logic [W-1:0] s_data_i,
  output logic         s_ready_o,
  output logic         m_valid_o,
  output logic [W-1:0] m_data_o,
  input  logic         m_ready_i
);
  logic         out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, ready_q, s_hs;
  logic [W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  assign s_hs      = s_valid_i & ready_q;
  assign s_ready_o = ready_q;
  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    // When the output slot frees, the skid entry is older than any new beat and goes first.
    if (!out_valid_q || m_ready_i) begin
      out_valid_d  = skid_valid_q | s_hs;
      out_data_d   = skid_valid_q ? skid_data_q : (s_hs ? s_data_i : out_data_q);
      skid_valid_d = 1'b0;
    end else if (s_hs) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data_i;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ~skid_valid_d;
    end
  end
endmodule

// File: rtl/parity_appender.sv
// parity_appender: AXI-Stream pass-through that appends an XOR parity trailer beat to every packet.
module parity_appender
  import parity_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              in_clock,
  input  logic              axis_areset,
  input  logic              axis_s_tvalid,
  input  logic [DATA_W-1:0] axis_s_tdata,
  output logic              axis_s_tready,
  input  logic              axis_s_tlast,
  output logic              axis_m_tvalid,
  output logic [DATA_W-1:0] axis_m_tdata,
  input  logic              axis_m_tready,
  output logic              axis_m_tlast,
  output logic [CNT_W-1:0]  pkt_count
);
  localparam logic [DATA_W-1:0] MASK = (ODD_PARITY != 0) ? ODD_MASK[DATA_W-1:0] : '0;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, buf_data;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              buf_valid, buf_ready, in_trail, trail_sel, s_hs, t_hs;
  axis_skid_buffer #(.W(DATA_W)) u_skid (
    .clk_i     (in_clock),
    .rst_i     (axis_areset),
    .s_valid_i (axis_s_tvalid & ~in_trail),
    .s_data_i  (axis_s_tdata),
    .s_ready_o (buf_ready),
    .m_valid_o (buf_valid),
    .m_data_o  (buf_data),
    .m_ready_i (axis_m_tready)
  );
  assign in_trail      = state_q == TRAIL;
  assign axis_s_tready = buf_ready & ~in_trail;
  assign s_hs          = axis_s_tvalid & axis_s_tready;
  // The trailer waits until the last payload beat has drained from the skid buffer.
  assign trail_sel     = in_trail & ~buf_valid;
  assign t_hs          = trail_sel & axis_m_tready;
  assign axis_m_tvalid = buf_valid | trail_sel;
  assign axis_m_tdata  = trail_sel ? acc_q ^ MASK : buf_data;
  assign axis_m_tlast  = trail_sel;
  assign pkt_count     = cnt_q;
  always_comb begin
    state_d = in_trail ? (t_hs ? IDLE : TRAIL) : (s_hs ? (axis_s_tlast ? TRAIL : PASS) : state_q);
    acc_d   = t_hs ? '0 : (s_hs ? acc_q ^ axis_s_tdata : acc_q);
    cnt_d   = t_hs ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge in_clock or posedge axis_areset) begin
    if (axis_areset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
